cas_player: RTL and testbench

- Plays back a cassette image that has already been downloaded into the TRS-80 cassette buffer (dn_addr 10000-1FFFF).
- Turns the stored bytes into the Level II 500-baud pulse stream that drives the cassette input of the trs80 core.
- Fetches bytes over a simple request/acknowledge read port into the cassette buffer RAM.
- Runs only while the cassette motor relay is on; pauses and resumes without losing its position.

---
 rtl/cas_player.sv | 251 +++++++++++++++++++++++++
 tb/tb_cas_player.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_player.sv
// cas_player: plays a downloaded cassette image out of the cassette buffer
// RAM as the Level II 500-baud pulse stream feeding the trs80 cassette input.
// Bytes come in over a req/ack read port; one shift byte plus one prefetch
// byte are buffered so consecutive bytes play back without a gap.

module cas_player #(
  parameter int CELL_CLKS  = 84000,
  parameter int PULSE_CLKS = 5376
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load_done,
  input  logic [16:0] image_len,
  input  logic        rewind,
  input  logic        motor,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic        cas_out,
  output logic        playing,
  output logic        eof,
  output logic [16:0] cas_pos
);

  localparam int CW = $clog2(CELL_CLKS);
  localparam logic [CW-1:0] C_ZERO     = CW'(0);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_LAST     = CW'(CELL_CLKS - 1);
  localparam logic [CW-1:0] C_PULSE    = CW'(PULSE_CLKS);
  localparam logic [CW-1:0] C_HALF     = CW'(CELL_CLKS / 2);
  localparam logic [CW-1:0] C_HALF_END = CW'(CELL_CLKS / 2 + PULSE_CLKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CELL  = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Output level at a given cell count: clock pulse at the start of every
  // cell, data pulse at mid-cell only for a 1 bit.
  function automatic logic pulse_level(input logic [CW-1:0] cnt, input logic bit_val);
    logic clk_p;
    logic dat_p;
    clk_p = (cnt < C_PULSE);
    dat_p = bit_val && (cnt >= C_HALF) && (cnt < C_HALF_END);
    return clk_p | dat_p;
  endfunction

  state_t        r_state;
  logic [16:0]   r_len;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pf_data;
  logic          r_pf_valid;
  logic          r_pf_need;
  logic [15:0]   r_fetch_addr;
  logic          r_discard;
  logic          r_req;
  logic [15:0]   r_addr;
  logic          r_cas_out;
  logic          r_playing;
  logic          r_eof;
  logic [16:0]   r_cas_pos;

  logic          w_strobe;
  logic          w_ack_take;
  logic          w_cur_bit;
  logic [16:0]   w_pos_inc;
  logic [17:0]   w_pos_plus2;
  logic          w_need_next;
  logic          w_need_after_move;

  assign w_strobe          = load_done | rewind;
  // Acknowledged data that belongs to the current playback (not a read left
  // over from before a rewind/load).
  assign w_ack_take        = r_req & rd_ack & ~r_discard;
  assign w_cur_bit         = r_shift[r_bit];
  assign w_pos_inc         = r_cas_pos + 17'd1;
  assign w_pos_plus2       = {1'b0, r_cas_pos} + 18'd2;
  // Byte at cas_pos is being loaded: is there a byte after it?
  assign w_need_next       = (w_pos_inc < r_len);
  // Byte cas_pos+1 is being loaded at a byte boundary: is there one after it?
  assign w_need_after_move = (w_pos_plus2 < {1'b0, r_len});

  // Playback state machine, read port handshake and all registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_len        <= 17'd0;
      r_shift      <= 8'd0;
      r_bit        <= 3'd0;
      r_cnt        <= C_ZERO;
      r_pf_data    <= 8'd0;
      r_pf_valid   <= 1'b0;
      r_pf_need    <= 1'b0;
      r_fetch_addr <= 16'd0;
      r_discard    <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= 16'd0;
      r_cas_out    <= 1'b0;
      r_playing    <= 1'b0;
      r_eof        <= 1'b0;
      r_cas_pos    <= 17'd0;
    end else if (w_strobe) begin
      // Restart from byte 0; an outstanding read still finishes its
      // handshake but its data is thrown away.
      if (load_done) begin
        r_len <= image_len;
      end else begin
        r_len <= r_len;
      end
      r_state    <= S_IDLE;
      r_cas_pos  <= 17'd0;
      r_eof      <= 1'b0;
      r_cas_out  <= 1'b0;
      r_playing  <= 1'b0;
      r_pf_valid <= 1'b0;
      r_pf_need  <= 1'b0;
      if (r_req) begin
        if (rd_ack) begin
          r_req     <= 1'b0;
          r_discard <= 1'b0;
        end else begin
          r_discard <= 1'b1;
        end
      end else begin
        r_discard <= 1'b0;
      end
    end else begin
      // Read port: hold the request until acked, then issue any pending one.
      if (r_req) begin
        if (rd_ack) begin
          r_req     <= 1'b0;
          r_discard <= 1'b0;
        end else begin
          r_req <= 1'b1;
        end
      end else if (r_pf_need) begin
        r_req     <= 1'b1;
        r_addr    <= r_fetch_addr;
        r_pf_need <= 1'b0;
      end else begin
        r_req <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cas_out <= 1'b0;
          r_playing <= 1'b0;
          if (motor) begin
            if (r_len != 17'd0) begin
              r_state      <= S_FETCH;
              r_pf_need    <= 1'b1;
              r_fetch_addr <= r_cas_pos[15:0];
            end else begin
              r_eof <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_FETCH, S_STALL: begin
          // Waiting for the byte at cas_pos; playback starts the cycle after its ack.
          r_cas_out <= 1'b0;
          r_playing <= 1'b0;
          if (w_ack_take) begin
            r_shift      <= rd_data;
            r_bit        <= 3'd7;
            r_cnt        <= C_ZERO;
            r_state      <= S_CELL;
            r_cas_out    <= motor;
            r_playing    <= motor;
            r_pf_need    <= w_need_next;
            r_fetch_addr <= w_pos_inc[15:0];
          end else begin
            r_state <= r_state;
          end
        end

        S_CELL: begin
          if (w_ack_take) begin
            r_pf_data  <= rd_data;
            r_pf_valid <= 1'b1;
          end else begin
            r_pf_data <= r_pf_data;
          end
          if (!motor) begin
            r_cas_out <= 1'b0;
            r_playing <= 1'b0;
          end else begin
            r_playing <= 1'b1;
            if (r_cnt != C_LAST) begin
              r_cnt     <= r_cnt + C_ONE;
              r_cas_out <= pulse_level(r_cnt + C_ONE, w_cur_bit);
            end else if (r_bit != 3'd0) begin
              r_bit     <= r_bit - 3'd1;
              r_cnt     <= C_ZERO;
              r_cas_out <= pulse_level(C_ZERO, 1'b0);
            end else begin
              r_cas_pos <= w_pos_inc;
              if (w_pos_inc == r_len) begin
                r_state   <= S_DONE;
                r_eof     <= 1'b1;
                r_cas_out <= 1'b0;
                r_playing <= 1'b0;
              end else if (r_pf_valid || w_ack_take) begin
                // Prefetch ready (or arriving right now): no gap between bytes.
                r_shift      <= r_pf_valid ? r_pf_data : rd_data;
                r_pf_valid   <= 1'b0;
                r_bit        <= 3'd7;
                r_cnt        <= C_ZERO;
                r_cas_out    <= pulse_level(C_ZERO, 1'b0);
                r_pf_need    <= w_need_after_move;
                r_fetch_addr <= w_pos_plus2[15:0];
              end else begin
                r_state   <= S_STALL;
                r_cas_out <= 1'b0;
                r_playing <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          r_eof     <= 1'b1;
          r_cas_out <= 1'b0;
          r_playing <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_cas_out <= 1'b0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req  = r_req;
  assign rd_addr = r_addr;
  assign cas_out = r_cas_out;
  assign playing = r_playing;
  assign eof     = r_eof;
  assign cas_pos = r_cas_pos;

endmodule

// File: tb/tb_cas_player.sv
// Directed testbench for cas_player with short cells (40 clocks, 4-clock pulses).
module tb_cas_player;

  logic        clk_sys;
  logic        reset_n;
  logic        load_done;
  logic [16:0] image_len;
  logic        rewind;
  logic        motor;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic        cas_out;
  logic        playing;
  logic        eof;
  logic [16:0] cas_pos;

  int          vectors;
  int          miscompares;
  int          ack_delay;
  int          age;
  logic        last_ack;
  logic [7:0]  ram [0:3];

  cas_player #(.CELL_CLKS(40), .PULSE_CLKS(4)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load_done (load_done),
    .image_len (image_len),
    .rewind    (rewind),
    .motor     (motor),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .cas_out   (cas_out),
    .playing   (playing),
    .eof       (eof),
    .cas_pos   (cas_pos)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: checks the read handshake, then updates the RAM model which
  // acks ack_delay cycles after it first sees rd_req.
  task automatic tick();
    logic        pr;
    logic        pk;
    logic [15:0] pa;
    pr = rd_req;
    pk = rd_ack;
    pa = rd_addr;
    @(posedge clk_sys);
    #1;
    if (pr) begin
      if (pk) begin
        check("req_drop", rd_req, 0);
      end else begin
        check("req_hold", rd_req, 1);
        check("addr_hold", rd_addr, pa);
      end
    end
    last_ack = pk;
    if (rd_ack) begin
      rd_ack = 1'b0;
      age = 0;
    end else if (rd_req) begin
      age++;
      if (age >= ack_delay) begin
        rd_ack  = 1'b1;
        rd_data = ram[rd_addr[1:0]];
      end
    end else begin
      age = 0;
    end
  endtask

  task automatic wait_rise(input int maxc);
    int n;
    n = 0;
    while (cas_out !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    check("rise_timeout", cas_out, 1);
  endtask

  task automatic wait_pos(input logic [16:0] p, input int maxc);
    int n;
    n = 0;
    while (cas_pos !== p && n < maxc) begin
      tick();
      n++;
    end
    check("pos_timeout", cas_pos, p);
  endtask

  // Check nc cells of byte b starting at cell c0 (cell 0 = MSB).
  task automatic expect_pattern(input logic [7:0] b, input int c0, input int nc);
    for (int c = c0; c < c0 + nc; c++) begin
      for (int off = 0; off < 40; off++) begin
        logic e;
        e = (off < 4) || (b[7-c] && off >= 20 && off < 24);
        check("cas_level", cas_out, e);
        tick();
      end
    end
  endtask

  task automatic load(input logic [16:0] len);
    image_len = len;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; ack_delay = 2; age = 0; last_ack = 1'b0;
    reset_n = 1'b0; load_done = 1'b0; image_len = 17'd0; rewind = 1'b0;
    motor = 1'b0; rd_ack = 1'b0; rd_data = 8'h00;
    ram[0] = 8'hA5; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_cas_out", cas_out, 0);
    check("rst_playing", playing, 0);
    check("rst_eof", eof, 0);
    check("rst_cas_pos", cas_pos, 0);
    reset_n = 1'b1;
    tick(); tick();
    check("idle_motor_off_eof", eof, 0);
    check("idle_motor_off_req", rd_req, 0);

    // Two-byte image {A5,00}, fast RAM
    motor = 1'b1;
    load(17'd2);
    check("load_eof", eof, 0);
    check("load_pos", cas_pos, 0);
    wait_rise(20);
    check("play_playing", playing, 1);
    check("play_pos0", cas_pos, 0);
    expect_pattern(8'hA5, 0, 8);
    check("play_pos1", cas_pos, 1);
    expect_pattern(8'h00, 0, 8);
    check("done_eof", eof, 1);
    check("done_pos", cas_pos, 2);
    check("done_cas", cas_out, 0);
    check("done_playing", playing, 0);

    // Ack without a request is ignored
    rd_ack = 1'b1;
    rd_data = 8'hFF;
    tick();
    check("spur_eof", eof, 1);
    check("spur_pos", cas_pos, 2);
    check("spur_req", rd_req, 0);
    tick();
    check("spur_cas", cas_out, 0);

    // Slow RAM: the prefetch of byte 1 lands after byte 0 has finished.
    // Prefetch rises 1 cycle after byte 0 starts and is acked 360 later, so
    // byte 1 starts 361 cycles after byte 0: a 41-cycle stall.
    ram[0] = 8'h5A; ram[1] = 8'hC3;
    ack_delay = 360;
    load(17'd2);
    check("stall_load_eof", eof, 0);
    wait_rise(800);
    expect_pattern(8'h5A, 0, 8);
    n = 0;
    while (cas_out !== 1'b1 && n < 100) begin
      check("stall_playing", playing, 0);
      check("stall_pos", cas_pos, 1);
      tick();
      n++;
    end
    check("stall_len", n, 41);
    check("stall_ack_prev", last_ack, 1);
    expect_pattern(8'hC3, 0, 8);
    check("stall_eof", eof, 1);
    check("stall_end_pos", cas_pos, 2);

    // Motor pause at cell count 10 of the first cell of byte 80
    ack_delay = 2;
    ram[0] = 8'h80;
    load(17'd1);
    wait_rise(20);
    repeat (10) tick();
    check("pause_pre", cas_out, 0);
    motor = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("pause_cas", cas_out, 0);
      check("pause_playing", playing, 0);
    end
    motor = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      tick();
      check("resume_cas", cas_out, (10 + k >= 20) && (10 + k < 24));
      check("resume_playing", playing, 1);
    end
    tick();
    expect_pattern(8'h80, 1, 7);
    check("pause_eof", eof, 1);
    check("pause_end_pos", cas_pos, 1);

    // Rewind while the prefetch of byte 2 is outstanding
    ram[0] = 8'hA5; ram[1] = 8'h00; ram[2] = 8'h00;
    load(17'd3);
    wait_pos(17'd1, 800);
    check("rw_cell_start", cas_out, 1);
    check("rw_req_idle", rd_req, 0);
    tick();
    check("rw_req_pf", rd_req, 1);
    check("rw_addr_pf", rd_addr, 2);
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    check("rw_pos", cas_pos, 0);
    check("rw_eof", eof, 0);
    check("rw_cas", cas_out, 0);
    check("rw_playing", playing, 0);
    check("rw_req_held", rd_req, 1);
    tick();
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rw_restart_req", rd_req, 1);
    check("rw_restart_addr", rd_addr, 0);
    check("rw_restart_pos", cas_pos, 0);
    wait_rise(20);
    expect_pattern(8'hA5, 0, 2);

    // Asynchronous reset in the middle of a cell
    wait_pos(17'd1, 400);
    tick();
    check("mid_cas", cas_out, 1);
    check("mid_req", rd_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rd_req", rd_req, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_cas_out", cas_out, 0);
    check("arst_playing", playing, 0);
    check("arst_eof", eof, 0);
    check("arst_cas_pos", cas_pos, 0);
    rd_ack = 1'b0;
    age = 0;
    repeat (2) @(posedge clk_sys);
    #3;
    reset_n = 1'b1;
    tick(); tick();
    check("len0_eof", eof, 1);
    check("len0_req", rd_req, 0);
    check("len0_pos", cas_pos, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
